// File: rtl/echo_effect_if.sv
// Sample stream bundle between the effect controller FIFOs and the echo stage.
// The controller side is the master; the echo stage is the slave.
interface echo_effect_if #(
  parameter int d_width = 16
);
  logic               i_data_ready;
  logic [d_width-1:0] i_data;
  logic               i_tx_full;
  logic               o_read_enable;
  logic [d_width-1:0] o_data;
  logic               o_data_valid;

  modport master (
    output i_data_ready,
    output i_data,
    output i_tx_full,
    input  o_read_enable,
    input  o_data,
    input  o_data_valid
  );

  modport slave (
    input  i_data_ready,
    input  i_data,
    input  i_tx_full,
    output o_read_enable,
    output o_data,
    output o_data_valid
  );
endinterface

// File: rtl/echo_effect.sv
// Echo stage: pops a sample, mixes it with an attenuated copy from a circular
// delay line, saturates, and pushes the result downstream.
module echo_effect #(
  parameter int d_width     = 16,
  parameter int addr_width  = 12,
  parameter int decay_shift = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   sw,
  echo_effect_if.slave bus,
  output logic         o_busy
);

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    POP     = 3'd2,
    CAPTURE = 3'd3,
    MEMRD   = 3'd4,
    CALC    = 3'd5,
    PUSH    = 3'd6
  } state_t;

  localparam logic [addr_width-1:0] ptr_one = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] ptr_last = {addr_width{1'b1}};

  state_t                     state_r;
  logic [addr_width-1:0]      ptr_r;
  logic [1:0]                 sw_r;
  logic signed [d_width-1:0]  x_r;
  logic signed [d_width-1:0]  d_r;
  logic signed [d_width-1:0]  sum_r;
  logic signed [d_width-1:0]  ram_q_r;
  logic signed [d_width-1:0]  mem_r [2**addr_width];

  logic                       ram_we_s;
  logic                       ram_rd_s;
  logic signed [d_width-1:0]  ram_wdata_s;
  logic signed [d_width-1:0]  sum_s;
  logic signed [d_width-1:0]  result_s;

  function automatic logic signed [d_width-1:0] sat_add(
    input logic signed [d_width-1:0] a,
    input logic signed [d_width-1:0] b
  );
    logic [d_width:0] wide;
    wide = {a[d_width-1], a} + {b[d_width-1], b};
    if (wide[d_width] != wide[d_width-1]) begin
      if (wide[d_width]) begin
        sat_add = {1'b1, {(d_width-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(d_width-1){1'b1}}};
      end
    end else begin
      sat_add = wide[d_width-1:0];
    end
  endfunction

  // Mix path and delay-line write data selection.
  always_comb begin
    sum_s       = sat_add(x_r, d_r >>> decay_shift);
    ram_we_s    = 1'b0;
    ram_rd_s    = 1'b0;
    ram_wdata_s = '0;
    if (sw_r[0]) begin
      result_s = sum_s;
    end else begin
      result_s = x_r;
    end
    case (state_r)
      CLEAR: begin
        ram_we_s = 1'b1;
      end
      CAPTURE: begin
        ram_rd_s = 1'b1;
      end
      PUSH: begin
        ram_we_s = 1'b1;
        // Bypass and single echo store the dry sample so the line stays primed.
        if (sw_r == 2'b11) begin
          ram_wdata_s = sum_r;
        end else begin
          ram_wdata_s = x_r;
        end
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Single-port delay memory; the clear sweep and the sample path share ptr_r.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ptr_r] <= ram_wdata_s;
    end else if (ram_rd_s) begin
      ram_q_r <= mem_r[ptr_r];
    end
  end

  // Sequencer with registered handshake strobes and output sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= CLEAR;
      ptr_r             <= '0;
      sw_r              <= 2'b00;
      x_r               <= '0;
      d_r               <= '0;
      sum_r             <= '0;
      bus.o_read_enable <= 1'b0;
      bus.o_data        <= '0;
      bus.o_data_valid  <= 1'b0;
      o_busy            <= 1'b1;
    end else begin
      bus.o_read_enable <= 1'b0;
      bus.o_data_valid  <= 1'b0;
      case (state_r)
        CLEAR: begin
          ptr_r <= ptr_r + ptr_one;
          if (ptr_r == ptr_last) begin
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end
        end
        IDLE: begin
          sw_r <= sw;
          if (bus.i_data_ready && !bus.i_tx_full) begin
            bus.o_read_enable <= 1'b1;
            state_r           <= POP;
          end
        end
        POP: begin
          state_r <= CAPTURE;
        end
        CAPTURE: begin
          x_r     <= bus.i_data;
          state_r <= MEMRD;
        end
        MEMRD: begin
          d_r     <= ram_q_r;
          state_r <= CALC;
        end
        CALC: begin
          sum_r            <= sum_s;
          bus.o_data       <= result_s;
          bus.o_data_valid <= 1'b1;
          state_r          <= PUSH;
        end
        PUSH: begin
          ptr_r   <= ptr_r + ptr_one;
          state_r <= IDLE;
        end
        default: begin
          ptr_r   <= '0;
          o_busy  <= 1'b1;
          state_r <= CLEAR;
        end
      endcase
    end
  end

endmodule
